pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder.sv | 153 +++++++++++++++
 tb/tb_pipelined_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Purpose: WIDTH-bit adder (a + b + c_in) split into STAGES ripple chunks, with one chunk per pipeline stage.
// Latency: STAGES cycles from input transfer to out_valid; one result per cycle while out_ready is high.
// Backpressure: valid/ready; empty stages keep accepting (bubbles collapse); in_ready drops only when every stage is full and stalled.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake for a, b, c_in
//   out_valid / out_ready result handshake for sum, carry (and ovf)
//   sum, carry            (a + b + c_in) mod 2^WIDTH and carry-out of bit WIDTH-1
//   ovf                   signed overflow; present only when ADDER_OVF_EN is defined
// WIDTH must be a multiple of STAGES.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = WIDTH / STAGES;

    // Per-stage state: valid, carry out of this stage's chunk, the sum bits
    // produced so far, and the operands travelling alongside for later chunks.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] nxt_v;
    logic [STAGES-1:0] nxt_c;
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [WIDTH-1:0]  nxt_a [STAGES];
    logic [WIDTH-1:0]  nxt_b [STAGES];

`ifdef ADDER_OVF_EN
    logic ovf_nxt;
    logic ovf_q;
`endif

    // A stage is blocked only if it and every stage downstream of it hold
    // data while the sink refuses. Scanning from the output end with a
    // running "all full and stalled" term avoids a self-referencing chain.
    always_comb begin : advance
        logic blocked;
        blocked = !out_ready;
        adv     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            blocked = blocked && v_q[k];
            adv[k]  = !blocked;
        end
    end

    assign in_ready = adv[0];

    // What each stage would load this cycle: its upstream operands plus the
    // chunk k sum, placed above the sum bits already produced upstream.
    always_comb begin : chunk_add
        int               p;
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] base;
        logic             cin;
        logic [CW:0]      t;
        nxt_v = '0;
        nxt_c = '0;
`ifdef ADDER_OVF_EN
        ovf_nxt = 1'b0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            p = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                op_a     = a;
                op_b     = b;
                cin      = c_in;
                base     = '0;
                nxt_v[k] = in_valid && adv[0];
            end else begin
                op_a     = a_q[p];
                op_b     = b_q[p];
                cin      = c_q[p];
                base     = s_q[p];
                nxt_v[k] = v_q[p];
            end
            t = {1'b0, op_a[k*CW +: CW]} + {1'b0, op_b[k*CW +: CW]} + {{CW{1'b0}}, cin};
            nxt_s[k]              = base;
            nxt_s[k][k*CW +: CW]  = t[CW-1:0];
            nxt_c[k]              = t[CW];
            nxt_a[k]              = op_a;
            nxt_b[k]              = op_b;
`ifdef ADDER_OVF_EN
            // Final stage sees the complete sum, so the sign test lives here.
            if (k == STAGES - 1) begin
                ovf_nxt = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (nxt_s[k][WIDTH-1] != op_a[WIDTH-1]);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k] <= nxt_v[k];
                    c_q[k] <= nxt_c[k];
                    s_q[k] <= nxt_s[k];
                    a_q[k] <= nxt_a[k];
                    b_q[k] <= nxt_b[k];
                end
            end
        end
    end

`ifdef ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv[STAGES-1]) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign ovf = ovf_q;
`endif

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry     = c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Purpose: self-checking bench for pipelined_adder (WIDTH=16, STAGES=4).
// Latency: n/a (bench).
// Backpressure: drives out_ready low to fill the pipe, then drains it.
module tb_pipelined_adder;

    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         c_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         carry;
    logic [W-1:0] sum;
`ifdef ADDER_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;
    int outs  = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t   e;
        longint u;
        longint sr;
        u   = longint'(x) + longint'(y) + longint'(ci);
        sr  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        e.s = W'(u);
        e.c = (u >= (longint'(1) << W));
        e.o = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: inputs change just after posedge, so at negedge the
    // handshakes seen here are exactly those the next posedge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (q.size() == 0) begin
                chk("out_valid_idle", out_valid, 0);
            end else if (out_valid) begin
                chk("mon_sum", sum, q[0].s);
                chk("mon_carry", carry, q[0].c);
`ifdef ADDER_OVF_EN
                chk("mon_ovf", ovf, q[0].o);
`endif
                if (out_ready) begin
                    void'(q.pop_front());
                    outs++;
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, c_in));
        end
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic got;
        int   n;
        a = x; b = y; c_in = ci; in_valid = 1'b1;
        n = 0;
        do begin
            #1;
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!got && n < 50);
        chk("send_accept", got, 1);
        in_valid = 1'b0;
    endtask

    // Returns how many posedges (counting the transfer edge) until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    logic [W-1:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hA5A5, 16'h0001, 16'h7FFF, 16'hC3C3};
    logic [W-1:0] vb [8] = '{16'h1111, 16'h0001, 16'h8000, 16'hF0F0, 16'h5A5A, 16'hFFFF, 16'h7FFF, 16'h3C3C};

    initial begin
        int   lat;
        int   idx;
        int   n;
        int   outs0;
        logic got;

        // Reset state, with out_ready low to show in_ready ignores it when empty.
        out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_carry", carry, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Single vector: latency and value.
        send(16'h158A, 16'h7095, 1'b0);
        wait_out(lat);
        chk("latency", lat, S);
        chk("v1_sum", sum, 16'h861F);
        chk("v1_carry", carry, 0);
        repeat (2) begin @(posedge clk); #1; end

        // Back-to-back: results on consecutive cycles, in order.
        send(16'h158A, 16'h7095, 1'b0);
        send(16'hB903, 16'hC6BD, 1'b0);
        wait_out(lat);
        chk("b2b_first_sum", sum, 16'h861F);
        @(posedge clk);
        #1;
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_sum", sum, 16'h7FC0);
        chk("b2b_second_carry", carry, 1);

        // Carry generated in chunk 0 ripples through every chunk.
        send(16'hFFFF, 16'h0000, 1'b1);
        wait_out(lat);
        chk("ripple_sum", sum, 16'h0000);
        chk("ripple_carry", carry, 1);

`ifdef ADDER_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_out(lat);
        chk("ovf_pos_sum", sum, 16'h8000);
        chk("ovf_pos_carry", carry, 0);
        chk("ovf_pos_ovf", ovf, 1);
        send(16'h8000, 16'h8000, 1'b0);
        wait_out(lat);
        chk("ovf_neg_sum", sum, 16'h0000);
        chk("ovf_neg_carry", carry, 1);
        chk("ovf_neg_ovf", ovf, 1);
`endif
        repeat (3) begin @(posedge clk); #1; end

        // Backpressure: 6 stalled cycles fill exactly S stages.
        outs0 = outs;
        out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            a = va[idx]; b = vb[idx]; c_in = 1'b0; in_valid = 1'b1;
            #1;
            got = in_ready;
            @(posedge clk);
            #1;
            if (got) idx++;
        end
        chk("bp_accepts", idx, S);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_sum_held", sum, 16'h2345);
        chk("bp_carry_held", carry, 0);
        out_ready = 1'b1;
        while (idx < 8) begin
            send(va[idx], vb[idx], 1'b0);
            idx++;
        end
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_all_out", outs - outs0, 8);

        // Asynchronous reset with results in flight.
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0);
        send(16'h0303, 16'h0404, 1'b0);
        send(16'h0505, 16'h0606, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_async_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("post_reset_idle", out_valid, 0);
        end
        chk("post_reset_in_ready", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
